// File: rtl/beam_pkg.sv
// Shared constants and types for the delay-and-sum alignment front end.
package beam_pkg;

    localparam int NUM_CH = 16;
    localparam int DATA_W = 23;
    localparam int DEPTH  = 32;
    localparam int DLY_W  = $clog2(DEPTH);
    localparam int CH_W   = 4;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic [DLY_W-1:0]         dly_t;
    typedef logic [DLY_W:0]           fill_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        READ    = 2'd1,
        PRESENT = 2'd2
    } align_state_t;

    localparam fill_t             FILL_MAX = fill_t'(DEPTH);
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);

    // Frame count including the frame being assembled, saturating at DEPTH.
    function automatic fill_t fill_sat_inc(input fill_t f);
        fill_t r;
        if (f >= FILL_MAX) begin
            r = FILL_MAX;
        end else begin
            r = f + fill_t'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/beam_delay_ram.sv
// One channel's circular sample history: one write port, one registered read port.
module beam_delay_ram
    import beam_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    we,
    input  dly_t    waddr,
    input  sample_t wdata,
    input  logic    re,
    input  dly_t    raddr,
    output sample_t rdata
);

    sample_t mem_r [DEPTH];
    sample_t rdata_r;

    // Storage array; contents are deliberately not reset, the fill count masks stale entries.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port, loaded only when a read is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= '0;
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/beam_delay_align.sv
// Collects one time-multiplexed frame of NUM_CH samples, delays each channel by a
// programmable number of frames and presents the aligned frame to the summing tree.
// Optional feature: define BEAM_ALIGN_MUTE_EN to add the cfg_mute per-channel mute port.
module beam_delay_align
    import beam_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [3:0]               s_ch,
    input  logic [DATA_W-1:0]        s_data,
    input  logic                     cfg_we,
    input  logic [3:0]               cfg_ch,
    input  logic [DLY_W-1:0]         cfg_delay,
`ifdef BEAM_ALIGN_MUTE_EN
    input  logic [NUM_CH-1:0]        cfg_mute,
`endif
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [NUM_CH*DATA_W-1:0] m_data,
    output logic                     frame_err
);

    align_state_t              state_r;
    logic [CH_W-1:0]           ch_cnt_r;
    dly_t                      wr_ptr_r;
    fill_t                     fill_r;
    dly_t                      dly_tab_r [NUM_CH];
    logic                      s_ready_r;
    logic                      m_valid_r;
    logic [NUM_CH*DATA_W-1:0]  m_data_r;
    logic                      frame_err_r;
    logic [NUM_CH-1:0]         zero_r;

    logic                      accept_s;
    logic                      ch_match_s;
    logic                      ram_re_s;
    fill_t                     fill_cur_s;
    logic [NUM_CH-1:0]         mute_s;
    logic [NUM_CH-1:0]         ram_we_s;
    logic [NUM_CH-1:0]         zero_s;
    dly_t                      raddr_s   [NUM_CH];
    sample_t                   ram_q_s   [NUM_CH];
    logic [NUM_CH*DATA_W-1:0]  frame_s;

`ifdef BEAM_ALIGN_MUTE_EN
    assign mute_s = cfg_mute;
`else
    assign mute_s = '0;
`endif

    assign accept_s   = s_valid & s_ready_r;
    assign ch_match_s = (s_ch == ch_cnt_r);
    assign ram_re_s   = (state_r == READ);
    assign fill_cur_s = fill_sat_inc(fill_r);

    // Per-channel write enable, delayed read address and zero-mask decision.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ram_we_s[c] = accept_s & ch_match_s & (s_ch == CH_W'(c));
            raddr_s[c]  = wr_ptr_r - dly_tab_r[c];
            zero_s[c]   = ({1'b0, dly_tab_r[c]} >= fill_cur_s) | mute_s[c];
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ram
            beam_delay_ram u_ram (
                .clk   (clk),
                .rst_n (rst_n),
                .we    (ram_we_s[g]),
                .waddr (wr_ptr_r),
                .wdata (sample_t'(s_data)),
                .re    (ram_re_s),
                .raddr (raddr_s[g]),
                .rdata (ram_q_s[g])
            );
        end
    endgenerate

    // Assemble the outgoing frame, forcing masked channels to zero.
    always_comb begin
        frame_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (zero_r[c]) begin
                frame_s[c*DATA_W +: DATA_W] = '0;
            end else begin
                frame_s[c*DATA_W +: DATA_W] = ram_q_s[c];
            end
        end
    end

    // Delay table: writable in any state; READ sees the value registered before its edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                dly_tab_r[c] <= '0;
            end
        end else if (cfg_we) begin
            dly_tab_r[cfg_ch] <= cfg_delay;
        end
    end

    // Collect / read / present sequencer with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= COLLECT;
            ch_cnt_r    <= '0;
            wr_ptr_r    <= '0;
            fill_r      <= '0;
            s_ready_r   <= 1'b1;
            m_valid_r   <= 1'b0;
            m_data_r    <= '0;
            frame_err_r <= 1'b0;
            zero_r      <= '0;
        end else begin
            case (state_r)
                COLLECT: begin
                    if (accept_s) begin
                        if (ch_match_s) begin
                            if (ch_cnt_r == LAST_CH) begin
                                ch_cnt_r  <= '0;
                                s_ready_r <= 1'b0;
                                state_r   <= READ;
                            end else begin
                                ch_cnt_r <= ch_cnt_r + CH_W'(1);
                            end
                        end else begin
                            // Out-of-order channel: abandon the partial frame, keep wr_ptr.
                            frame_err_r <= 1'b1;
                            ch_cnt_r    <= '0;
                        end
                    end
                end
                READ: begin
                    zero_r  <= zero_s;
                    state_r <= PRESENT;
                end
                PRESENT: begin
                    if (!m_valid_r) begin
                        m_data_r  <= frame_s;
                        m_valid_r <= 1'b1;
                    end else if (m_ready) begin
                        m_valid_r <= 1'b0;
                        wr_ptr_r  <= wr_ptr_r + DLY_W'(1);
                        fill_r    <= fill_cur_s;
                        s_ready_r <= 1'b1;
                        state_r   <= COLLECT;
                    end
                end
                default: begin
                    state_r   <= COLLECT;
                    ch_cnt_r  <= '0;
                    s_ready_r <= 1'b1;
                    m_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready   = s_ready_r;
    assign m_valid   = m_valid_r;
    assign m_data    = m_data_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_beam_delay_align.sv
// Scoreboard bench for beam_delay_align: expected frames are queued at stimulus time
// and compared by an independent monitor on each m_valid/m_ready handshake.
module tb_beam_delay_align;

    localparam int NCH = 16;
    localparam int DW  = 23;
    localparam int FW  = NCH * DW;

    logic          clk;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [3:0]    s_ch;
    logic [DW-1:0] s_data;
    logic          cfg_we;
    logic [3:0]    cfg_ch;
    logic [4:0]    cfg_delay;
`ifdef BEAM_ALIGN_MUTE_EN
    logic [NCH-1:0] cfg_mute;
`endif
    logic          m_valid;
    logic          m_ready;
    logic [FW-1:0] m_data;
    logic          frame_err;

    int checks;
    int failures;
    logic [FW-1:0] exp_q [$];
    logic [FW-1:0] mon_exp;

    beam_delay_align dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_ch      (s_ch),
        .s_data    (s_data),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_delay (cfg_delay),
`ifdef BEAM_ALIGN_MUTE_EN
        .cfg_mute  (cfg_mute),
`endif
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor: pop and compare on every accepted output frame.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame actual=%h required=none", m_data);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("frame", m_data, mon_exp);
            end
        end
    end

    task automatic send_sample(input logic [3:0] ch, input logic [DW-1:0] d);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_ch    = ch;
        s_data  = d;
        while (!s_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("s_ready_wait", FW'(s_ready), FW'(1));
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [FW-1:0] din, input logic [FW-1:0] exp, input bit push);
        if (push) exp_q.push_back(exp);
        for (int c = 0; c < NCH; c++) begin
            send_sample(4'(c), din[c*DW +: DW]);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", FW'(exp_q.size()), FW'(0));
        @(posedge clk); #1;
    endtask

    task automatic wait_mvalid();
        int n;
        n = 0;
        while (!m_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_m_valid", FW'(m_valid), FW'(1));
    endtask

    task automatic cfg_write(input logic [3:0] ch, input logic [4:0] d);
        cfg_we    = 1'b1;
        cfg_ch    = ch;
        cfg_delay = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        cfg_we  = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    logic [FW-1:0] din;
    logic [FW-1:0] exp;
    logic [FW-1:0] held;

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_ch      = 4'd0;
        s_data    = '0;
        cfg_we    = 1'b0;
        cfg_ch    = 4'd0;
        cfg_delay = 5'd0;
        m_ready   = 1'b1;
`ifdef BEAM_ALIGN_MUTE_EN
        cfg_mute  = '0;
`endif
        do_reset();

        // Reset state
        chk("rst_s_ready", FW'(s_ready), FW'(1));
        chk("rst_m_valid", FW'(m_valid), FW'(0));
        chk("rst_m_data", m_data, '0);
        chk("rst_frame_err", FW'(frame_err), FW'(0));

        // Delays 0: ch c carries c+1; m_valid rises two edges after the last sample
        for (int c = 0; c < NCH; c++) din[c*DW +: DW] = DW'(c + 1);
        send_frame(din, din, 1'b1);
        chk("lat_t", FW'(m_valid), FW'(0));
        @(posedge clk); #1;
        chk("lat_t1", FW'(m_valid), FW'(0));
        @(posedge clk); #1;
        chk("lat_t2", FW'(m_valid), FW'(1));
        wait_idle();

        // delay[3]=2 over three fresh frames: ch3 gives 0,0,0x100
        do_reset();
        cfg_write(4'd3, 5'd2);
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < NCH; c++) din[c*DW +: DW] = DW'(32'h200 + 16 * f + c);
            din[3*DW +: DW] = DW'(32'h100 + f);
            exp = din;
            exp[3*DW +: DW] = (f == 2) ? DW'(32'h100) : DW'(0);
            send_frame(din, exp, 1'b1);
        end
        wait_idle();

        // Channel order error: 0,1,2,5 drops ch5 and flags; following full frame is good
        cfg_write(4'd3, 5'd0);
        send_sample(4'd0, 23'h00aa0);
        send_sample(4'd1, 23'h00aa1);
        send_sample(4'd2, 23'h00aa2);
        send_sample(4'd5, 23'h00aa5);
        chk("frame_err_set", FW'(frame_err), FW'(1));
        for (int c = 0; c < NCH; c++) din[c*DW +: DW] = DW'(32'h1000 + c);
        send_frame(din, din, 1'b1);
        wait_idle();
        chk("frame_err_sticky", FW'(frame_err), FW'(1));

        // Back-pressure: hold m_ready low for 10 cycles in PRESENT
        m_ready = 1'b0;
        for (int c = 0; c < NCH; c++) din[c*DW +: DW] = DW'(32'h3000 + c);
        send_frame(din, din, 1'b1);
        wait_mvalid();
        held = m_data;
        s_valid = 1'b1;
        s_ch    = 4'd0;
        s_data  = 23'h7abcd;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("hold_m_data", m_data, held);
            chk("hold_s_ready", FW'(s_ready), FW'(0));
        end
        chk("hold_m_valid", FW'(m_valid), FW'(1));
        s_valid = 1'b0;
        m_ready = 1'b1;
        wait_idle();
        // wr_ptr moved by exactly one: delay 1 on ch5 returns the held frame's ch5
        cfg_write(4'd5, 5'd1);
        for (int c = 0; c < NCH; c++) din[c*DW +: DW] = DW'(32'h4000 + c);
        exp = din;
        exp[5*DW +: DW] = 23'h03005;
        send_frame(din, exp, 1'b1);
        wait_idle();

        // 40 frames with delay[0]=31: pointer wrap and fill saturation
        do_reset();
        cfg_write(4'd0, 5'd31);
        for (int f = 0; f < 40; f++) begin
            for (int c = 0; c < NCH; c++) din[c*DW +: DW] = DW'(32'h10000 + 16 * f + c);
            din[0 +: DW] = DW'(f);
            exp = din;
            exp[0 +: DW] = (f >= 31) ? DW'(f - 31) : DW'(0);
            send_frame(din, exp, 1'b1);
        end
        wait_idle();

        // Asynchronous reset while a frame is being presented
        m_ready = 1'b0;
        for (int c = 0; c < NCH; c++) din[c*DW +: DW] = DW'(32'h6000 + c);
        send_frame(din, din, 1'b0);
        wait_mvalid();
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_m_valid", FW'(m_valid), FW'(0));
        chk("arst_m_data", m_data, '0);
        chk("arst_s_ready", FW'(s_ready), FW'(1));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_ready = 1'b1;
        @(posedge clk); #1;
        chk("arst_frame_err", FW'(frame_err), FW'(0));
        for (int c = 0; c < NCH; c++) din[c*DW +: DW] = DW'(32'h5000 + c);
        send_frame(din, din, 1'b1);
        wait_idle();

`ifdef BEAM_ALIGN_MUTE_EN
        cfg_mute = 16'h0001;
        for (int c = 0; c < NCH; c++) din[c*DW +: DW] = DW'(32'h7000 + c);
        exp = din;
        exp[0 +: DW] = '0;
        send_frame(din, exp, 1'b1);
        wait_idle();
        cfg_mute = 16'h0000;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
